loop_replay_ctrl: RTL and testbench
===================================

// Module: loop_replay_ctrl
// PURPOSE
//   Loop-buffer controller behind the stream loop detector in the fetch/IFID path.
//   - On a detected backward loop, captures one iteration of the instruction stream into a small buffer.
//   - Replays that iteration into IFID while blocking I-fetch, until a mispredict ends the loop.
//   - Sequences capture, replay and exit, and owns the fetch-block decision while a loop is active.
// PARAMETERS
//   DEPTH  8   buffer entries = max loop body length in instructions
//   AW     3   pointer width, log2(DEPTH)
//   XLEN   32  PC width
// PORTS
//   clk          in   1     clock
//   reset        in   1     synchronous, active-high
//   loop_detect  in   1     1-cycle pulse from loop detector: backward branch/JAL resolved
//   loop_start   in   XLEN  loop target PC (branch PC + immediate), valid with loop_detect
//   loop_end     in   XLEN  PC of the backward branch, valid with loop_detect
//   mispredict   in   1     pipeline mispredict/flush; highest priority
//   if_valid     in   1     fetch delivers if_pc/if_instr this cycle
//   if_pc        in   XLEN  PC of fetched instruction
//   if_instr     in   32    fetched instruction
//   stall        in   1     IFID stall; replay holds
//   rp_valid     out  1     replayed instruction valid
//   rp_pc        out  XLEN  PC of replayed instruction
//   rp_instr     out  32    replayed instruction
//   fetch_block  out  1     1 = suppress I-cache fetch; IFID takes rp_*
//   fill_abort   out  1     1-cycle pulse: capture abandoned
// BEHAVIOUR
//   - Reset: state IDLE; rp_valid, fetch_block and fill_abort are 0.
//     rp_pc and rp_instr are 0. Pointers are 0. Buffer RAM is not reset.
//   - All outputs are registered.
//   - Priority: reset > mispredict > all other events. loop_detect is ignored outside IDLE.
//   - IDLE, on loop_detect:
//     - Compute diff = loop_end - loop_start (XLEN, unsigned) and len = diff[XLEN-1:2] + 1.
//     - Accept if loop_end >= loop_start, diff[1:0] == 0 and len <= DEPTH.
//     - Accept: latch start, end and len; clear wr_ptr; enter FILL next cycle.
//     - Reject: stay in IDLE with no output change. A single-instruction loop (start == end, len 1) is legal.
//   - FILL (fetch_block = 0):
//     - On if_valid with if_pc == start + 4*wr_ptr: buf[wr_ptr] <= if_instr; wr_ptr++.
//     - The write where if_pc == end moves the FSM to REPLAY with rd_ptr = 0.
//     - if_valid with any other PC (taken branch inside body, redirect) -> IDLE, fill_abort = 1 for one cycle.
//     - mispredict -> IDLE, fill_abort = 1.
//     - if_valid = 0 leaves state and pointers unchanged.
//   - REPLAY (fetch_block = 1, registered; first asserted the cycle after the loop_end write):
//     - Each cycle with stall = 0: rp_valid = 1, rp_pc = start + 4*rd_ptr, rp_instr = buf[rd_ptr].
//     - rd_ptr advances and wraps from len-1 to 0.
//     - stall = 1: rp_* and rd_ptr hold, and rp_valid stays at its current value.
//   - REPLAY exit on mispredict:
//     - Next cycle: rp_valid = 0, fetch_block = 0, state IDLE.
//     - The redirect target comes from the pipeline, not from this block.
//   - Latency:
//     - loop_detect at cycle N -> FILL at N+1.
//     - loop_end written at cycle M -> first rp_valid at M+1 with rp_pc = start.
//   - Same-cycle cases:
//     - mispredict with loop_detect in IDLE: loop_detect is dropped.
//     - mispredict with the final FILL write: go to IDLE, not REPLAY.
//   - Reset mid-FILL/REPLAY: IDLE next cycle, outputs at reset values, no fill_abort pulse.
// TESTING
//   1. Fill: loop_detect, start=0x00, end=0x0C; fetch 0x00,0x04,0x08,0x0C with instr A,B,C,D.
//      -> fetch_block=1 the next cycle; rp_pc 0x00,0x04,0x08,0x0C,0x00...; rp_instr A,B,C,D,A...
//   2. Reject: start=0x00, end=0x20 (len 9 > DEPTH 8); also start=0x20, end=0x00.
//      -> stay IDLE, fetch_block=0, no fill_abort.
//   3. Abort: during FILL of 0x00..0x0C, fetch 0x00 then 0x40.
//      -> fill_abort pulses once, IDLE, rp_valid never asserted.
//   4. Stall and exit: in REPLAY hold stall=1 for 3 cycles at rp_pc=0x08, then mispredict.
//      -> rp_pc stays 0x08 during the stall; the cycle after mispredict, rp_valid=0 and fetch_block=0.
//   5. Single-instruction loop: start=end=0x10, fetch 0x10 instr X.
//      -> rp_pc=0x10 and rp_instr=X every unstalled cycle.
//   6. Reset in REPLAY, plus mispredict in the same cycle as loop_detect in IDLE.
//      -> both end in IDLE with all outputs 0.

Source files
------------

// File: rtl/loop_replay_ctrl.sv
// Loop buffer: captures one iteration of a detected backward loop,
// then replays it into IFID with I-fetch blocked until a mispredict.
module loop_replay_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            loop_detect,
   input  logic [XLEN-1:0] loop_start,
   input  logic [XLEN-1:0] loop_end,
   input  logic            mispredict,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   input  logic            stall,
   output logic            rp_valid,
   output logic [XLEN-1:0] rp_pc,
   output logic [31:0]     rp_instr,
   output logic            fetch_block,
   output logic            fill_abort
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      REPLAY = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [XLEN-1:0] start_q, start_d;
   logic [XLEN-1:0] end_q, end_d;
   logic [AW:0]     len_q, len_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

   logic            rp_valid_q, rp_valid_d;
   logic [XLEN-1:0] rp_pc_q, rp_pc_d;
   logic [31:0]     rp_instr_q, rp_instr_d;
   logic            fetch_block_q, fetch_block_d;
   logic            fill_abort_q, fill_abort_d;

   logic [31:0]     buf_q [DEPTH];
   logic            buf_we;

   logic [XLEN-1:0] diff;
   logic            accept;
   logic [XLEN-1:0] fill_pc;
   logic [XLEN-1:0] rd_pc;
   logic [AW-1:0]   rd_nxt;

   // Comparing diff>>2 against DEPTH-1 avoids wrap of len for huge spans
   assign diff    = loop_end - loop_start;
   assign accept  = (loop_end >= loop_start)
                 && (diff[1:0] == 2'b00)
                 && (diff[XLEN-1:2] < (XLEN-2)'(DEPTH));
   assign fill_pc = start_q + XLEN'({wr_ptr_q, 2'b00});
   assign rd_pc   = start_q + XLEN'({rd_ptr_q, 2'b00});
   assign rd_nxt  = ({1'b0, rd_ptr_q} == len_q - 1'b1)
                  ? '0 : rd_ptr_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      end_d        = end_q;
      len_d        = len_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rp_valid_d   = rp_valid_q;
      rp_pc_d      = rp_pc_q;
      rp_instr_d   = rp_instr_q;
      fill_abort_d = 1'b0;
      buf_we       = 1'b0;
      if (mispredict) begin
         state_d    = IDLE;
         rp_valid_d = 1'b0;
         if (state_q == FILL) fill_abort_d = 1'b1;
         if (state_q == REPLAY) begin
            rp_pc_d    = '0;
            rp_instr_d = '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (loop_detect && accept) begin
                  state_d  = FILL;
                  start_d  = loop_start;
                  end_d    = loop_end;
                  len_d    = {1'b0, diff[AW+1:2]} + 1'b1;
                  wr_ptr_d = '0;
               end
            end
            FILL: begin
               if (if_valid) begin
                  if (if_pc == fill_pc) begin
                     buf_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     if (if_pc == end_q) begin
                        // First replay slot is start; bypass for 1-entry loops
                        state_d    = REPLAY;
                        rp_valid_d = 1'b1;
                        rp_pc_d    = start_q;
                        rp_instr_d = (wr_ptr_q == '0) ? if_instr : buf_q[0];
                        rd_ptr_d   = (len_q == 1) ? '0 : AW'(1);
                     end
                  end else begin
                     state_d      = IDLE;
                     fill_abort_d = 1'b1;
                  end
               end
            end
            REPLAY: begin
               if (!stall) begin
                  rp_valid_d = 1'b1;
                  rp_pc_d    = rd_pc;
                  rp_instr_d = buf_q[rd_ptr_q];
                  rd_ptr_d   = rd_nxt;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      fetch_block_d = (state_d == REPLAY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         start_q       <= '0;
         end_q         <= '0;
         len_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         rp_valid_q    <= 1'b0;
         rp_pc_q       <= '0;
         rp_instr_q    <= '0;
         fetch_block_q <= 1'b0;
         fill_abort_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_d;
         end_q         <= end_d;
         len_q         <= len_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         rp_valid_q    <= rp_valid_d;
         rp_pc_q       <= rp_pc_d;
         rp_instr_q    <= rp_instr_d;
         fetch_block_q <= fetch_block_d;
         fill_abort_q  <= fill_abort_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we && !reset) buf_q[wr_ptr_q] <= if_instr;
   end

   assign rp_valid    = rp_valid_q;
   assign rp_pc       = rp_pc_q;
   assign rp_instr    = rp_instr_q;
   assign fetch_block = fetch_block_q;
   assign fill_abort  = fill_abort_q;

endmodule

// File: tb/tb_loop_replay_ctrl.sv
// Directed bench for loop_replay_ctrl: fill, reject, abort, stall,
// single-entry loops, depth boundary and reset/mispredict corners.
module tb_loop_replay_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        loop_detect = 1'b0;
   logic [31:0] loop_start = '0;
   logic [31:0] loop_end = '0;
   logic        mispredict = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_pc = '0;
   logic [31:0] if_instr = '0;
   logic        stall = 1'b0;
   logic        rp_valid;
   logic [31:0] rp_pc;
   logic [31:0] rp_instr;
   logic        fetch_block;
   logic        fill_abort;

   int checks = 0;
   int errors = 0;

   logic [31:0] ins [4] = '{32'hA000_0001, 32'hB000_0002,
                            32'hC000_0003, 32'hD000_0004};

   loop_replay_ctrl #(.DEPTH(8), .AW(3), .XLEN(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .loop_detect (loop_detect),
      .loop_start  (loop_start),
      .loop_end    (loop_end),
      .mispredict  (mispredict),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .stall       (stall),
      .rp_valid    (rp_valid),
      .rp_pc       (rp_pc),
      .rp_instr    (rp_instr),
      .fetch_block (fetch_block),
      .fill_abort  (fill_abort)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic detect(input logic [31:0] s, input logic [31:0] e);
      loop_detect = 1'b1;
      loop_start  = s;
      loop_end    = e;
      tick();
      loop_detect = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] ins_v);
      if_valid = 1'b1;
      if_pc    = pc;
      if_instr = ins_v;
      tick();
      if_valid = 1'b0;
   endtask

   task automatic mp_exit();
      mispredict = 1'b1;
      tick();
      mispredict = 1'b0;
   endtask

   task automatic fill4();
      detect(32'h0, 32'hC);
      for (int i = 0; i < 4; i++) fetch(32'(i * 4), ins[i]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b000 ||
          rp_pc !== 32'h0 || rp_instr !== 32'h0) begin
         errors++;
         $display("FAIL reset: flags=%b pc=%h instr=%h, want 000/0/0",
                  {rp_valid, fetch_block, fill_abort}, rp_pc, rp_instr);
      end
   endtask

   task automatic test_fill();
      detect(32'h0, 32'hC);
      for (int i = 0; i < 3; i++) begin
         fetch(32'(i * 4), ins[i]);
         checks++;
         if ({rp_valid, fetch_block, fill_abort} !== 3'b000) begin
            errors++;
            $display("FAIL fill_busy[%0d]: flags=%b want 000", i,
                     {rp_valid, fetch_block, fill_abort});
         end
      end
      fetch(32'hC, ins[3]);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({rp_valid, fetch_block, fill_abort} !== 3'b110 ||
             rp_pc !== 32'((i % 4) * 4) || rp_instr !== ins[i % 4]) begin
            errors++;
            $display("FAIL fill_replay[%0d]: flags=%b pc=%h instr=%h want 110 %h %h",
                     i, {rp_valid, fetch_block, fill_abort}, rp_pc, rp_instr,
                     32'((i % 4) * 4), ins[i % 4]);
         end
         tick();
      end
      mp_exit();
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b000) begin
         errors++;
         $display("FAIL fill_exit: flags=%b want 000",
                  {rp_valid, fetch_block, fill_abort});
      end
   endtask

   task automatic test_depth8();
      detect(32'h100, 32'h11C);
      for (int i = 0; i < 8; i++) fetch(32'h100 + 32'(i * 4), 32'h1000 + 32'(i));
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (rp_valid !== 1'b1 || rp_pc !== 32'h100 + 32'((i % 8) * 4) ||
             rp_instr !== 32'h1000 + 32'(i % 8)) begin
            errors++;
            $display("FAIL depth8[%0d]: v=%b pc=%h instr=%h want 1 %h %h", i,
                     rp_valid, rp_pc, rp_instr, 32'h100 + 32'((i % 8) * 4),
                     32'h1000 + 32'(i % 8));
         end
         tick();
      end
      mp_exit();
   endtask

   task automatic test_reject();
      logic [31:0] rs [3] = '{32'h0, 32'h20, 32'h0};
      logic [31:0] re [3] = '{32'h20, 32'h0, 32'hE};
      for (int i = 0; i < 3; i++) begin
         detect(rs[i], re[i]);
         fetch(32'h40, 32'h1);
         checks++;
         if ({rp_valid, fetch_block, fill_abort} !== 3'b000) begin
            errors++;
            $display("FAIL reject[%0d]: flags=%b want 000", i,
                     {rp_valid, fetch_block, fill_abort});
         end
      end
   endtask

   task automatic test_abort();
      detect(32'h0, 32'hC);
      fetch(32'h0, ins[0]);
      fetch(32'h40, 32'h5);
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b001) begin
         errors++;
         $display("FAIL abort_pulse: flags=%b want 001",
                  {rp_valid, fetch_block, fill_abort});
      end
      tick();
      checks++;
      if (fill_abort !== 1'b0) begin
         errors++;
         $display("FAIL abort_once: fill_abort=%b want 0", fill_abort);
      end
      for (int i = 1; i < 4; i++) fetch(32'(i * 4), ins[i]);
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle: flags=%b want 000",
                  {rp_valid, fetch_block, fill_abort});
      end
      detect(32'h0, 32'hC);
      fetch(32'h0, ins[0]);
      mp_exit();
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b001) begin
         errors++;
         $display("FAIL abort_mp: flags=%b want 001",
                  {rp_valid, fetch_block, fill_abort});
      end
      detect(32'h0, 32'hC);
      for (int i = 0; i < 3; i++) fetch(32'(i * 4), ins[i]);
      mispredict = 1'b1;
      fetch(32'hC, ins[3]);
      mispredict = 1'b0;
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b001) begin
         errors++;
         $display("FAIL abort_mp_last: flags=%b want 001",
                  {rp_valid, fetch_block, fill_abort});
      end
      tick();
   endtask

   task automatic test_stall();
      fill4();
      tick();
      tick();
      checks++;
      if (rp_pc !== 32'h8) begin
         errors++;
         $display("FAIL stall_pre: pc=%h want 00000008", rp_pc);
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rp_valid !== 1'b1 || rp_pc !== 32'h8 || rp_instr !== ins[2]) begin
            errors++;
            $display("FAIL stall_hold[%0d]: v=%b pc=%h instr=%h want 1 8 %h",
                     i, rp_valid, rp_pc, rp_instr, ins[2]);
         end
      end
      stall = 1'b0;
      mp_exit();
      checks++;
      if (rp_valid !== 1'b0 || fetch_block !== 1'b0) begin
         errors++;
         $display("FAIL stall_exit: v=%b fb=%b want 0 0", rp_valid, fetch_block);
      end
   endtask

   task automatic test_single();
      detect(32'h10, 32'h10);
      fetch(32'h10, 32'h5EED_0010);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rp_valid, fetch_block} !== 2'b11 || rp_pc !== 32'h10 ||
             rp_instr !== 32'h5EED_0010) begin
            errors++;
            $display("FAIL single[%0d]: v=%b fb=%b pc=%h instr=%h want 1 1 10 5eed0010",
                     i, rp_valid, fetch_block, rp_pc, rp_instr);
         end
         tick();
      end
      mp_exit();
   endtask

   task automatic test_reset_replay();
      fill4();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b000 ||
          rp_pc !== 32'h0 || rp_instr !== 32'h0) begin
         errors++;
         $display("FAIL reset_replay: flags=%b pc=%h instr=%h want 000/0/0",
                  {rp_valid, fetch_block, fill_abort}, rp_pc, rp_instr);
      end
      tick();
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b000) begin
         errors++;
         $display("FAIL reset_after: flags=%b want 000",
                  {rp_valid, fetch_block, fill_abort});
      end
      mispredict = 1'b1;
      detect(32'h0, 32'hC);
      mispredict = 1'b0;
      fetch(32'h40, 32'h7);
      checks++;
      if (fill_abort !== 1'b0) begin
         errors++;
         $display("FAIL mp_detect_abort: fill_abort=%b want 0", fill_abort);
      end
      for (int i = 0; i < 4; i++) fetch(32'(i * 4), ins[i]);
      checks++;
      if ({rp_valid, fetch_block, fill_abort} !== 3'b000 ||
          rp_pc !== 32'h0 || rp_instr !== 32'h0) begin
         errors++;
         $display("FAIL mp_detect_idle: flags=%b pc=%h instr=%h want 000/0/0",
                  {rp_valid, fetch_block, fill_abort}, rp_pc, rp_instr);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_reject();
      test_abort();
      test_stall();
      test_single();
      test_depth8();
      test_reset_replay();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
